// File: rtl/configurable_timer.sv
// configurable_timer: prescaled one-shot/periodic down-timer; TIMER_BLINK_EN makes indicator blink per tick
module configurable_timer #(
    parameter int TICK_DIV = 8,
    parameter int VALUE_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        startTimer,
    input  logic                        stopTimer,
    input  logic                        periodic,
    input  logic [VALUE_W-1:0]          value,
    output logic                        tick,
    output logic                        expired,
    output logic                        indicator,
    output logic [VALUE_W-1:0]          counter,
    output logic [$clog2(TICK_DIV)-1:0] counterTick
);
    localparam int CT_W = $clog2(TICK_DIV);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    logic [1:0]         r_state, w_state;
    logic [VALUE_W-1:0] r_cnt, w_cnt;
    logic [CT_W-1:0]    r_ct, w_ct;
    logic               r_per, w_per;
    logic               r_exp, w_exp;
    logic               r_tick, w_tick;
    logic               r_ind, w_ind;
    logic               r_start_d, r_rst_hi;
    logic               w_start, w_wrap;

    // r_rst_hi blocks a start input that was already high when reset released
    assign w_start = startTimer & ~r_start_d & ~r_rst_hi;
    assign w_wrap  = (r_ct == CT_W'(TICK_DIV - 1));

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ct    = r_ct;
        w_per   = r_per;
        w_exp   = r_exp;
        w_tick  = 1'b0;
        if (stopTimer) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_ct    = '0;
            w_exp   = 1'b0;
        end else if (w_start) begin
            w_cnt   = value;
            w_ct    = '0;
            w_per   = periodic;
            w_exp   = (value == '0);
            w_state = (value == '0) ? EXPIRED : RUNNING;
        end else if (r_state == RUNNING) begin
            w_ct  = w_wrap ? '0 : r_ct + CT_W'(1);
            w_exp = 1'b0;
            if (w_wrap) begin
                w_tick = 1'b1;
                if (r_cnt == VALUE_W'(1)) begin
                    w_exp   = 1'b1;
                    w_cnt   = r_per ? value : '0;
                    w_state = (r_per && value != '0) ? RUNNING : EXPIRED;
                end else begin
                    w_cnt = r_cnt - VALUE_W'(1);
                end
            end
        end
`ifdef TIMER_BLINK_EN
        w_ind = (w_state == IDLE)    ? 1'b0 :
                (w_state == EXPIRED) ? 1'b1 :
                w_start              ? 1'b0 :
                w_tick               ? ~r_ind : r_ind;
`else
        w_ind = (w_state == RUNNING);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ct      <= '0;
            r_per     <= 1'b0;
            r_exp     <= 1'b0;
            r_tick    <= 1'b0;
            r_ind     <= 1'b0;
            r_start_d <= 1'b0;
            r_rst_hi  <= startTimer;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_ct      <= w_ct;
            r_per     <= w_per;
            r_exp     <= w_exp;
            r_tick    <= w_tick;
            r_ind     <= w_ind;
            r_start_d <= startTimer;
            r_rst_hi  <= 1'b0;
        end
    end

    assign tick        = r_tick;
    assign expired     = r_exp;
    assign indicator   = r_ind;
    assign counter     = r_cnt;
    assign counterTick = r_ct;
endmodule

// File: tb/tb_configurable_timer.sv
// tb_configurable_timer: directed checks of configurable_timer with TICK_DIV=4, VALUE_W=4
module tb_configurable_timer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       startTimer = 1'b0;
    logic       stopTimer = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] value = 4'd0;
    logic       tick, expired, indicator;
    logic [3:0] counter;
    logic [1:0] counterTick;
    int checks = 0;
    int errors = 0;
`ifdef TIMER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    configurable_timer #(.TICK_DIV(4), .VALUE_W(4)) dut (
        .clock(clock), .reset(reset), .startTimer(startTimer), .stopTimer(stopTimer),
        .periodic(periodic), .value(value), .tick(tick), .expired(expired),
        .indicator(indicator), .counter(counter), .counterTick(counterTick)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [8:0] obs();
        return {tick, expired, indicator, counter, counterTick};
    endfunction

    function automatic logic [8:0] mk(int t, int e, int i, int c, int ct);
        return {t[0], e[0], i[0], c[3:0], ct[1:0]};
    endfunction

    // vectors are {tick,expired,indicator,counter,counterTick}
    task automatic test_reset();
        logic [8:0] w;
        cyc();
        cyc();
        w = mk(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL reset_held got=%b want=%b", obs(), w); end
        reset = 1'b0;
        cyc();
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL reset_idle got=%b want=%b", obs(), w); end
    endtask

    task automatic test_zero_value();
        logic [8:0] w;
        value = 4'd0; periodic = 1'b0; startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        w = mk(0, 1, BLINK ? 1 : 0, 0, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL zero_start got=%b want=%b", obs(), w); end
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL zero_hold k=%0d got=%b want=%b", k, obs(), w); end
        end
    endtask

    task automatic test_oneshot();
        logic [8:0] w;
        value = 4'd3; periodic = 1'b0; startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        w = mk(0, 0, BLINK ? 0 : 1, 3, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL oneshot_start got=%b want=%b", obs(), w); end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            w = mk(k % 4 == 0, k == 12, BLINK ? (k == 12 ? 1 : (k / 4) % 2) : (k < 12), 3 - k / 4, k % 4);
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL oneshot k=%0d got=%b want=%b", k, obs(), w); end
        end
        w = mk(0, 1, BLINK ? 1 : 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL oneshot_hold k=%0d got=%b want=%b", k, obs(), w); end
        end
    endtask

    task automatic test_periodic();
        logic [8:0] w;
        value = 4'd2; periodic = 1'b1; startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        w = mk(0, 0, BLINK ? 0 : 1, 2, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL periodic_start got=%b want=%b", obs(), w); end
        for (int k = 1; k <= 24; k++) begin
            cyc();
            w = mk(k % 4 == 0, k % 8 == 0, BLINK ? (k / 4) % 2 : 1, 2 - (k / 4) % 2, k % 4);
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL periodic k=%0d got=%b want=%b", k, obs(), w); end
        end
        stopTimer = 1'b1;
        cyc();
        stopTimer = 1'b0;
        w = mk(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL periodic_stop got=%b want=%b", obs(), w); end
    endtask

    task automatic test_restart();
        logic [8:0] w;
        value = 4'd3; periodic = 1'b0; startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        for (int k = 1; k <= 9; k++) cyc();
        w = mk(0, 0, BLINK ? 0 : 1, 1, 1);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL restart_pre got=%b want=%b", obs(), w); end
        value = 4'd5; startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        value = 4'd7;
        w = mk(0, 0, BLINK ? 0 : 1, 5, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL restart_load got=%b want=%b", obs(), w); end
        for (int j = 1; j <= 20; j++) begin
            cyc();
            w = mk(j % 4 == 0, j == 20, BLINK ? (j == 20 ? 1 : (j / 4) % 2) : (j < 20), 5 - j / 4, j % 4);
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL restart j=%0d got=%b want=%b", j, obs(), w); end
        end
    endtask

    task automatic test_stop_and_reset();
        logic [8:0] w;
        value = 4'd3; periodic = 1'b0; startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        cyc();
        cyc();
        w = mk(0, 0, BLINK ? 0 : 1, 3, 2);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL stop_pre got=%b want=%b", obs(), w); end
        stopTimer = 1'b1; startTimer = 1'b1;
        cyc();
        stopTimer = 1'b0;
        w = mk(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL stop_wins got=%b want=%b", obs(), w); end
        cyc();
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL stop_consumed got=%b want=%b", obs(), w); end
        startTimer = 1'b0;
        cyc();
        startTimer = 1'b1;
        cyc();
        startTimer = 1'b0;
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL reset_midrun got=%b want=%b", obs(), w); end
        startTimer = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL reset_held_start got=%b want=%b", obs(), w); end
        cyc();
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL reset_held_start2 got=%b want=%b", obs(), w); end
        startTimer = 1'b0;
        cyc();
    endtask

    task automatic test_held_start();
        logic [8:0] w;
        value = 4'd2; periodic = 1'b0; startTimer = 1'b1;
        cyc();
        w = mk(0, 0, BLINK ? 0 : 1, 2, 0);
        checks++;
        if (obs() !== w) begin errors++; $display("FAIL held_start got=%b want=%b", obs(), w); end
        for (int k = 1; k <= 19; k++) begin
            cyc();
            w = mk(k == 4 || k == 8, k >= 8, BLINK ? (k >= 8 ? 1 : (k / 4) % 2) : (k < 8),
                   k >= 8 ? 0 : 2 - k / 4, k >= 8 ? 0 : k % 4);
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL held k=%0d got=%b want=%b", k, obs(), w); end
        end
        startTimer = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_zero_value();
        test_oneshot();
        test_periodic();
        test_restart();
        test_stop_and_reset();
        test_held_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/configurable_timer.md
CONFIGURABLE_TIMER -- requirements
Module: configurable_timer

Interface
REQ-001 Parameter: TICK_DIV, default 8, clock cycles per tick (SHALL be >= 2).
REQ-002 Parameter: VALUE_W, default 4, width of load value and down-counter.
REQ-003 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: startTimer  input  1  start/restart request; acted on at its rising edge only.
REQ-006 Port: stopTimer  input  1  abort request; level-sensitive.
REQ-007 Port: periodic  input  1  0 = one-shot mode, 1 = auto-reload mode; sampled at start.
REQ-008 Port: value  input  VALUE_W  terminal count in ticks; sampled at start and at each periodic reload.
REQ-009 Port: tick  output  1  one-cycle pulse at each prescaler wrap while running.
REQ-010 Port: expired  output  1  timeout flag: held in one-shot mode, one-cycle pulse in periodic mode.
REQ-011 Port: indicator  output  1  status LED drive.
REQ-012 Port: counter  output  VALUE_W  remaining ticks.
REQ-013 Port: counterTick  output  $clog2(TICK_DIV)  prescaler count.

Function
REQ-014 States: IDLE, RUNNING, EXPIRED; all outputs registered.
REQ-015 Start event: startTimer=1 at an edge where startTimer was 0 at the previous edge; a held-high input yields exactly one start event.
REQ-016 On a start event in any state: counter<=value, counterTick<=0, periodic latched, expired<=0, state<=RUNNING, all at that same edge.
REQ-017 Start event with value==0: state<=EXPIRED, expired<=1 at that edge; no tick is generated.
REQ-018 RUNNING: counterTick increments by 1 per cycle, wrapping from TICK_DIV-1 to 0; on the wrap edge tick<=1 for one cycle and counter decrements by 1.
REQ-019 Latency: with start at edge N, tick pulses occur at edges N+k*TICK_DIV; expiry for value V occurs at edge N+V*TICK_DIV.
REQ-020 Decrement 1->0 in one-shot mode: state<=EXPIRED, counter=0, expired<=1 and held.
REQ-021 Decrement 1->0 in periodic mode: counter<=current value input (0 loads cause transition per REQ-017), expired pulses for one cycle, state stays RUNNING.
REQ-022 EXPIRED: counter and counterTick frozen, tick=0, expired=1, until a start event, stopTimer, or reset.
REQ-023 stopTimer=1: state<=IDLE, counter<=0, counterTick<=0, expired<=0, tick<=0.
REQ-024 Simultaneous stopTimer and start event: stop wins; the start event is consumed, not deferred.
REQ-025 Start event in RUNNING: restart per REQ-016; any partial prescaler count is discarded.
REQ-026 value changes while RUNNING have no effect until the next start event or periodic reload.

Reset
REQ-027 reset=1 at a clock edge: state<=IDLE; tick, expired, indicator, counter, counterTick, latched periodic and start-edge history all <=0.
REQ-028 reset has priority over stopTimer and start events; reset mid-run discards the count; a startTimer held high through reset release is NOT a start event.

Configuration
REQ-029 Macro TIMER_BLINK_EN defined: indicator toggles on each tick edge in RUNNING, is 0 in IDLE, 1 in EXPIRED, and is cleared to 0 on each start event.
REQ-030 Macro TIMER_BLINK_EN undefined: indicator=1 exactly when state is RUNNING, 0 otherwise; no toggle register is synthesised.

Verification (TICK_DIV=4, VALUE_W=4)
REQ-031 value=0, start pulse -> expired=1 at the start edge, counter=0, no tick for 20 cycles.
REQ-032 value=3, periodic=0, start at edge N -> tick at N+4, N+8, N+12; counter 3,2,1,0; expired=1 from N+12, held 20 cycles.
REQ-033 value=2, periodic=1 -> expired one-cycle pulses at N+8, N+16, N+24; counter reloads to 2 each time.
REQ-034 value=3 run; at counter=1, value=5 and new start -> counter=5, counterTick=0, expired at start+20.
REQ-035 stopTimer and start edge same cycle while RUNNING -> IDLE, counter=0; reset asserted mid-run -> all outputs 0 next cycle.
REQ-036 startTimer held high 20 cycles with value=2, one-shot -> single load, expired after 8 cycles; blink on/off per macro matches REQ-029/REQ-030.
